// File: rtl/writeback_regfile.sv
// Writeback stage with the architectural register file.
// Holds 15 x 64-bit registers (index 15 means "no register"), decodes the
// E and M destinations from the instruction code, tracks the processor
// status (AOK/HLT/ADR/INS) and counts retired instructions.
module writeback_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_en,
    input  logic [3:0]  in_code,
    input  logic        cnd,
    input  logic [3:0]  r_a,
    input  logic [3:0]  r_b,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    input  logic        bad_mem,
    input  logic        bad_instr,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a_out,
    output logic [63:0] val_b_out,
    output logic [1:0]  stat,
    output logic        halted,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    localparam logic [3:0] REG_NONE = 4'd15;
    localparam logic [3:0] REG_RSP  = 4'd4;

    stat_t       stat_r;
    stat_t       stat_next_s;
    logic [63:0] regs_r [0:14];
    logic [31:0] count_r;
    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;
    logic        retire_s;
    logic        commit_s;

    // Destination decode: which register receives val_e and which val_m.
    always_comb begin
        dst_e_s = REG_NONE;
        dst_m_s = REG_NONE;
        case (in_code)
            4'd2: begin
                if (cnd) begin
                    dst_e_s = r_b;
                end else begin
                    dst_e_s = REG_NONE;
                end
            end
            4'd3, 4'd6: dst_e_s = r_b;
            4'd5:       dst_m_s = r_a;
            4'd8, 4'd9, 4'd10: dst_e_s = REG_RSP;
            4'd11: begin
                dst_e_s = REG_RSP;
                dst_m_s = r_a;
            end
            default: begin
                dst_e_s = REG_NONE;
                dst_m_s = REG_NONE;
            end
        endcase
    end

    // Retire/commit qualification: a faulting instruction neither counts nor
    // writes, and the halt instruction counts but never writes.
    always_comb begin
        retire_s = wb_en && (stat_r == STAT_AOK) && !bad_instr && !bad_mem;
        if (in_code != 4'd0) begin
            commit_s = retire_s;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Status next-state: the first fault or halt wins and then sticks.
    always_comb begin
        stat_next_s = stat_r;
        case (stat_r)
            STAT_AOK: begin
                if (!wb_en) begin
                    stat_next_s = STAT_AOK;
                end else if (bad_instr) begin
                    stat_next_s = STAT_INS;
                end else if (bad_mem) begin
                    stat_next_s = STAT_ADR;
                end else if (in_code == 4'd0) begin
                    stat_next_s = STAT_HLT;
                end else begin
                    stat_next_s = STAT_AOK;
                end
            end
            STAT_HLT, STAT_ADR, STAT_INS: stat_next_s = stat_r;
            default: stat_next_s = STAT_INS;
        endcase
    end

    // Status register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_r <= STAT_AOK;
        end else begin
            stat_r <= stat_next_s;
        end
    end

    // Register file update; the memory result wins when both ports target
    // the same register (popq %rsp).
    always_ff @(posedge clock) begin
        for (int i = 0; i < 15; i++) begin
            if (reset) begin
                regs_r[i] <= (4'(i) == REG_RSP) ? 64'd1000 : 64'd0;
            end else if (commit_s && (dst_m_s == 4'(i))) begin
                regs_r[i] <= val_m;
            end else if (commit_s && (dst_e_s == 4'(i))) begin
                regs_r[i] <= val_e;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (retire_s && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Read ports return committed state only; index 15 reads as zero.
    always_comb begin
        val_a_out = 64'd0;
        val_b_out = 64'd0;
        if (src_a != REG_NONE) begin
            val_a_out = regs_r[src_a];
        end else begin
            val_a_out = 64'd0;
        end
        if (src_b != REG_NONE) begin
            val_b_out = regs_r[src_b];
        end else begin
            val_b_out = 64'd0;
        end
    end

    assign stat       = stat_r;
    assign halted     = (stat_r != STAT_AOK);
    assign inst_count = count_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: the driver pushes the expected
// pre-edge reads and post-edge state for every issued cycle, and a monitor
// process pops and compares them against the DUT.
module tb_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [3:0]  in_code = 4'd1;
    logic        cnd = 1'b0;
    logic [3:0]  r_a = 4'd15;
    logic [3:0]  r_b = 4'd15;
    logic [63:0] val_e = 64'd0;
    logic [63:0] val_m = 64'd0;
    logic        bad_mem = 1'b0;
    logic        bad_instr = 1'b0;
    logic [3:0]  src_a = 4'd15;
    logic [3:0]  src_b = 4'd15;
    logic [63:0] val_a_out;
    logic [63:0] val_b_out;
    logic [1:0]  stat;
    logic        halted;
    logic [31:0] inst_count;

    writeback_regfile dut (
        .clock(clock), .reset(reset), .wb_en(wb_en), .in_code(in_code),
        .cnd(cnd), .r_a(r_a), .r_b(r_b), .val_e(val_e), .val_m(val_m),
        .bad_mem(bad_mem), .bad_instr(bad_instr), .src_a(src_a), .src_b(src_b),
        .val_a_out(val_a_out), .val_b_out(val_b_out), .stat(stat),
        .halted(halted), .inst_count(inst_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          chk_pre;
        logic [63:0] pre_a;
        logic [63:0] pre_b;
        logic [63:0] post_a;
        logic [63:0] post_b;
        logic [1:0]  stat;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural state as plain arrays.
    logic [63:0] m_regs [16];
    logic [1:0]  m_stat = 2'd0;
    logic [31:0] m_cnt = 32'd0;
    bit          m_known = 1'b0;

    function automatic logic [63:0] m_read(input logic [3:0] a);
        if (a == 4'd15) return 64'd0;
        return m_regs[a];
    endfunction

    task automatic m_write(input logic [3:0] d, input logic [63:0] v);
        if (d != 4'd15) m_regs[d] = v;
    endtask

    task automatic model_step(input bit rst, input bit we, input logic [3:0] code,
                              input bit c, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] ve, input logic [63:0] vm,
                              input bit bm, input bit bi);
        logic [3:0] de;
        logic [3:0] dm;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_regs[k] = 64'd0;
            m_regs[4] = 64'd1000;
            m_stat = 2'd0;
            m_cnt = 32'd0;
            m_known = 1'b1;
            return;
        end
        if (!we || m_stat != 2'd0) return;
        if (bi) begin m_stat = 2'd3; return; end
        if (bm) begin m_stat = 2'd2; return; end
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (code == 4'd0) begin m_stat = 2'd1; return; end
        de = 4'd15;
        dm = 4'd15;
        if ((code == 4'd2 && c) || code == 4'd3 || code == 4'd6) de = rb;
        if (code inside {4'd8, 4'd9, 4'd10, 4'd11}) de = 4'd4;
        if (code == 4'd5 || code == 4'd11) dm = ra;
        m_write(de, ve);
        m_write(dm, vm);   // applied last so M wins on a shared destination
    endtask

    task automatic issue(input bit rst, input bit we, input logic [3:0] code,
                         input bit c, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input bit bm, input bit bi,
                         input logic [3:0] sa, input logic [3:0] sb);
        exp_t e;
        @(negedge clock);
        reset = rst; wb_en = we; in_code = code; cnd = c; r_a = ra; r_b = rb;
        val_e = ve; val_m = vm; bad_mem = bm; bad_instr = bi; src_a = sa; src_b = sb;
        e.chk_pre = m_known;
        e.pre_a = m_read(sa);
        e.pre_b = m_read(sb);
        model_step(rst, we, code, c, ra, rb, ve, vm, bm, bi);
        e.post_a = m_read(sa);
        e.post_b = m_read(sb);
        e.stat = m_stat;
        e.halted = (m_stat != 2'd0);
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic idle_read(input logic [3:0] sa, input logic [3:0] sb);
        issue(1'b0, 1'b0, 4'd1, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0, 1'b0, sa, sb);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per issued cycle and compares the reads
    // before the edge and the state after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q[0];
                if (e.chk_pre) begin
                    chk("pre_val_a", val_a_out, e.pre_a);
                    chk("pre_val_b", val_b_out, e.pre_b);
                end
                @(posedge clock);
                #1;
                chk("post_val_a", val_a_out, e.post_a);
                chk("post_val_b", val_b_out, e.post_b);
                chk("stat", {62'd0, stat}, {62'd0, e.stat});
                chk("halted", {63'd0, halted}, {63'd0, e.halted});
                chk("inst_count", {32'd0, inst_count}, {32'd0, e.cnt});
                void'(sb_q.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic, then a sweep.
    initial begin
        int wait_cycles;
        issue(1'b1, 1'b0, 4'd1, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0, 1'b0, 4'd4, 4'd0);
        issue(1'b1, 1'b1, 4'd3, 1'b0, 4'd15, 4'd2, 64'd5, 64'd0, 1'b1, 1'b1, 4'd4, 4'd15);
        // irmovq into %rdx
        issue(1'b0, 1'b1, 4'd3, 1'b0, 4'd15, 4'd2, 64'h55, 64'd0, 1'b0, 1'b0, 4'd2, 4'd4);
        idle_read(4'd2, 4'd4);
        // popq %rsp: M wins over the stack-pointer update
        issue(1'b0, 1'b1, 4'd11, 1'b0, 4'd4, 4'd15, 64'd1008, 64'h77, 1'b0, 1'b0, 4'd4, 4'd2);
        // cmov not taken, then taken
        issue(1'b0, 1'b1, 4'd2, 1'b0, 4'd15, 4'd3, 64'd9, 64'd0, 1'b0, 1'b0, 4'd3, 4'd15);
        issue(1'b0, 1'b1, 4'd2, 1'b1, 4'd15, 4'd3, 64'd9, 64'd0, 1'b0, 1'b0, 4'd3, 4'd15);
        // rmmovq writes nothing; call and OPq
        issue(1'b0, 1'b1, 4'd4, 1'b0, 4'd3, 4'd3, 64'hAA, 64'hBB, 1'b0, 1'b0, 4'd3, 4'd4);
        issue(1'b0, 1'b1, 4'd8, 1'b0, 4'd15, 4'd15, 64'd992, 64'd0, 1'b0, 1'b0, 4'd4, 4'd3);
        issue(1'b0, 1'b1, 4'd6, 1'b0, 4'd1, 4'd14, 64'hDEAD, 64'd0, 1'b0, 1'b0, 4'd14, 4'd1);
        // out-of-range code without bad_instr: no register write
        issue(1'b0, 1'b1, 4'd13, 1'b1, 4'd1, 4'd1, 64'h1234, 64'h5678, 1'b0, 1'b0, 4'd1, 4'd4);
        // faults ignored while wb_en is low
        issue(1'b0, 1'b0, 4'd5, 1'b0, 4'd1, 4'd15, 64'd0, 64'h99, 1'b1, 1'b1, 4'd1, 4'd15);
        // mrmovq with address fault, then a blocked irmovq
        issue(1'b0, 1'b1, 4'd5, 1'b0, 4'd1, 4'd15, 64'd0, 64'h99, 1'b1, 1'b0, 4'd1, 4'd15);
        issue(1'b0, 1'b1, 4'd3, 1'b0, 4'd15, 4'd1, 64'h42, 64'd0, 1'b0, 1'b0, 4'd1, 4'd15);
        // both faults together: instruction fault wins
        issue(1'b1, 1'b0, 4'd1, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0, 1'b0, 4'd4, 4'd15);
        issue(1'b0, 1'b1, 4'd5, 1'b0, 4'd1, 4'd15, 64'd0, 64'h99, 1'b1, 1'b1, 4'd1, 4'd15);
        // halt, then reset out of HLT
        issue(1'b1, 1'b0, 4'd1, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0, 1'b0, 4'd4, 4'd15);
        issue(1'b0, 1'b1, 4'd3, 1'b0, 4'd15, 4'd4, 64'd7, 64'd0, 1'b0, 1'b0, 4'd4, 4'd15);
        issue(1'b0, 1'b1, 4'd0, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 1'b0, 1'b0, 4'd4, 4'd15);
        issue(1'b1, 1'b1, 4'd3, 1'b0, 4'd15, 4'd4, 64'd3, 64'd0, 1'b0, 1'b0, 4'd4, 4'd15);

        for (int n = 0; n < 600; n++) begin
            bit          r_rst;
            bit          r_we;
            logic [3:0]  r_code;
            r_rst  = ($urandom_range(0, 99) < 3);
            r_we   = ($urandom_range(0, 3) != 0);
            r_code = ($urandom_range(0, 99) < 2) ? 4'd0 : 4'($urandom_range(1, 15));
            issue(r_rst, r_we, r_code, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 2),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        for (int s = 0; s < 16; s++) begin
            idle_read(4'(s), 4'(15 - s));
        end

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clock);
            wait_cycles++;
        end
        repeat (2) @(posedge clock);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
